// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : alu_pkg
// Purpose  : Shared definitions for the ALU command dispatcher: opcodes,
//            response error codes, dispatcher FSM states and the command
//            payload layout.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU opcodes
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Response status codes
    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;

    // Dispatcher FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } disp_state_t;

    // Fixed-width part of a command. The tag width is chosen per instance,
    // so the tag is appended below this struct in the FIFO word:
    // {opcode, a, b, tag}.
    typedef struct packed {
        logic [1:0] opcode;
        logic [7:0] a;
        logic [7:0] b;
    } alu_cmd_core_t;

    localparam int CMD_CORE_W = 18;

    // DIV is only legal when the attached ALU was built with a divider.
    function automatic logic is_illegal_op(input logic [1:0] op, input logic div_en);
        return (op == OP_DIV) && !div_en;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_fifo
// Purpose  : Synchronous command FIFO. Registered-pointer design with an
//            extra wrap bit on each pointer to tell full from empty. Read
//            data is the current head; a word written at an edge is visible
//            only after that edge (no fall-through).
// Ports    : clk, rst         - clock, synchronous active-high reset
//            push, wdata      - write request and data (ignored when full)
//            pop, rdata       - read request (ignored when empty), head data
//            full, empty      - occupancy flags
//            count            - occupancy, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 22
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int               c_aw      = $clog2(DEPTH);
    localparam logic [c_aw:0]    c_ptr_one = (c_aw + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Same index with differing wrap bits means the writer lapped the reader.
    assign full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign count = r_wr_ptr - r_rd_ptr;
    assign rdata = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : alu_dispatcher
// Purpose  : Buffers ALU requests in a small FIFO, issues them one at a time
//            to alu_top with a start/done handshake, and returns each 16-bit
//            result with its tag and a status code on a valid/ready port.
// Ports    : clk, rst                        - clock, sync active-high reset
//            cmd_valid/ready, cmd_opcode/a/b/tag - command input
//            alu_start, alu_opcode, alu_operand_A/B - request to alu_top
//            alu_result, alu_done            - completion from alu_top
//            rsp_valid/ready, rsp_result/opcode/tag/err - response output
//            busy, fifo_count                - status
// Revision : 1.0 - initial release
// ============================================================================
module alu_dispatcher
    import alu_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ENABLE_DIV     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_opcode,
    input  logic [7:0]              cmd_a,
    input  logic [7:0]              cmd_b,
    input  logic [TAG_W-1:0]        cmd_tag,
    output logic                    alu_start,
    output logic [1:0]              alu_opcode,
    output logic [7:0]              alu_operand_A,
    output logic [7:0]              alu_operand_B,
    input  logic [15:0]             alu_result,
    input  logic                    alu_done,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [15:0]             rsp_result,
    output logic [1:0]              rsp_opcode,
    output logic [TAG_W-1:0]        rsp_tag,
    output logic [1:0]              rsp_err,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int                 c_fifo_w   = CMD_CORE_W + TAG_W;
    localparam int                 c_tmr_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tmr_w-1:0] c_tmo_last = c_tmr_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_tmr_one  = c_tmr_w'(1);
    localparam logic               c_div_en   = (ENABLE_DIV != 0);

    disp_state_t          r_state;
    logic [c_tmr_w-1:0]   r_timer;
    logic                 r_alu_start;
    logic [1:0]           r_alu_opcode;
    logic [7:0]           r_alu_a;
    logic [7:0]           r_alu_b;
    logic [TAG_W-1:0]     r_tag;
    logic                 r_rsp_valid;
    logic [15:0]          r_rsp_result;
    logic [1:0]           r_rsp_opcode;
    logic [TAG_W-1:0]     r_rsp_tag;
    logic [1:0]           r_rsp_err;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [c_fifo_w-1:0]  w_head;
    alu_cmd_core_t        w_head_core;
    logic [TAG_W-1:0]     w_head_tag;

    // Ready depends only on registered FIFO state, so a pop in this cycle
    // never makes room for a push in the same cycle.
    assign cmd_ready   = !w_full && !rst;
    assign w_push      = cmd_valid && cmd_ready;
    assign w_pop       = (r_state == ST_IDLE) && !w_empty;
    assign w_head_core = w_head[c_fifo_w-1:TAG_W];
    assign w_head_tag  = w_head[TAG_W-1:0];

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_fifo_w)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .wdata ({cmd_opcode, cmd_a, cmd_b, cmd_tag}),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_timer      <= '0;
            r_alu_start  <= 1'b0;
            r_alu_opcode <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_tag        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_opcode <= '0;
            r_rsp_tag    <= '0;
            r_rsp_err    <= '0;
        end else begin
            r_alu_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        if (is_illegal_op(w_head_core.opcode, c_div_en)) begin
                            // Rejected without touching the ALU interface.
                            r_rsp_valid  <= 1'b1;
                            r_rsp_result <= '0;
                            r_rsp_opcode <= w_head_core.opcode;
                            r_rsp_tag    <= w_head_tag;
                            r_rsp_err    <= ERR_ILLEGAL;
                            r_state      <= ST_RESP;
                        end else begin
                            r_alu_opcode <= w_head_core.opcode;
                            r_alu_a      <= w_head_core.a;
                            r_alu_b      <= w_head_core.b;
                            r_tag        <= w_head_tag;
                            r_alu_start  <= 1'b1;
                            r_state      <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    // done is not looked at here; it may only follow start.
                    r_timer <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (alu_done) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_result <= alu_result;
                        r_rsp_opcode <= r_alu_opcode;
                        r_rsp_tag    <= r_tag;
                        r_rsp_err    <= ERR_OK;
                        r_state      <= ST_RESP;
                    end else if (r_timer == c_tmo_last) begin
                        // This is the TIMEOUT_CYCLES-th WAIT cycle without done.
                        r_rsp_valid  <= 1'b1;
                        r_rsp_result <= '0;
                        r_rsp_opcode <= r_alu_opcode;
                        r_rsp_tag    <= r_tag;
                        r_rsp_err    <= ERR_TIMEOUT;
                        r_state      <= ST_RESP;
                    end else begin
                        r_timer <= r_timer + c_tmr_one;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_start     = r_alu_start;
    assign alu_opcode    = r_alu_opcode;
    assign alu_operand_A = r_alu_a;
    assign alu_operand_B = r_alu_b;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_result    = r_rsp_result;
    assign rsp_opcode    = r_rsp_opcode;
    assign rsp_tag       = r_rsp_tag;
    assign rsp_err       = r_rsp_err;
    assign busy          = (r_state != ST_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_alu_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_dispatcher
// Purpose  : Self-checking bench for alu_dispatcher with a behavioural
//            alu_top stand-in whose latency is chosen per command.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_dispatcher;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int TMO   = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_opcode = '0;
    logic [7:0]        cmd_a = '0;
    logic [7:0]        cmd_b = '0;
    logic [TAG_W-1:0]  cmd_tag = '0;
    logic              alu_start;
    logic [1:0]        alu_opcode;
    logic [7:0]        alu_operand_A;
    logic [7:0]        alu_operand_B;
    logic [15:0]       alu_result = '0;
    logic              alu_done = 1'b0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [15:0]       rsp_result;
    logic [1:0]        rsp_opcode;
    logic [TAG_W-1:0]  rsp_tag;
    logic [1:0]        rsp_err;
    logic              busy;
    logic [2:0]        fifo_count;

    always #5 clk = ~clk;

    alu_dispatcher #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT_CYCLES(TMO), .ENABLE_DIV(0)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_start(alu_start), .alu_opcode(alu_opcode),
        .alu_operand_A(alu_operand_A), .alu_operand_B(alu_operand_B),
        .alu_result(alu_result), .alu_done(alu_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_opcode(rsp_opcode), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .busy(busy), .fifo_count(fifo_count)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arithmetic the ALU is defined to perform: 16-bit, wrapping.
    function automatic logic [15:0] alu_math(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_ADD:  return 16'(a) + 16'(b);
            OP_SUB:  return 16'(a) - 16'(b);
            OP_MUL:  return 16'(a) * 16'(b);
            default: return 16'hBEEF;
        endcase
    endfunction

    typedef struct {
        logic [15:0]      res;
        logic [1:0]       op;
        logic [1:0]       err;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    // Latency 0 means the ALU never answers.
    function automatic rsp_t predict(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                     input logic [TAG_W-1:0] tag, input int lat);
        rsp_t r;
        r.op  = op;
        r.tag = tag;
        if (op == OP_DIV) begin
            r.res = 16'h0; r.err = ERR_ILLEGAL;
        end else if (lat == 0 || lat > TMO) begin
            r.res = 16'h0; r.err = ERR_TIMEOUT;
        end else begin
            r.res = alu_math(op, a, b); r.err = ERR_OK;
        end
        return r;
    endfunction

    // ---------------- behavioural alu_top ----------------
    int          lat_q[$];
    rsp_t        exp_q[$];
    int          alu_cnt     = 0;
    int          start_count = 0;
    logic        prev_start  = 1'b0;
    logic [15:0] alu_hold    = '0;

    always @(negedge clk) begin
        alu_done   = 1'b0;
        alu_result = 16'hDEAD;
        if (rst) begin
            alu_cnt    = 0;
            prev_start = 1'b0;
        end else begin
            if (alu_start) begin
                start_count++;
                checks++;
                if (prev_start) begin
                    failures++;
                    $display("FAIL start_pulse: got 2-cycle start expected 1-cycle");
                end
                alu_hold = alu_math(alu_opcode, alu_operand_A, alu_operand_B);
                alu_cnt  = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
            end else if (alu_cnt > 0) begin
                alu_cnt--;
                if (alu_cnt == 0) begin
                    alu_done   = 1'b1;
                    alu_result = alu_hold;
                end
            end
            prev_start = alu_start;
        end
    end

    task automatic check_rsp();
        rsp_t e;
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL rsp_unexpected: got tag %0h expected none", rsp_tag);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_fields", {rsp_result, rsp_opcode, rsp_err, rsp_tag}, {e.res, e.op, e.err, e.tag});
            end
        end
    endtask

    task automatic drive_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input logic [TAG_W-1:0] tag);
        cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
    endtask

    typedef struct {
        logic [1:0]       op;
        logic [7:0]       a;
        logic [7:0]       b;
        logic [TAG_W-1:0] tag;
        int               lat;
        logic [15:0]      exp_res;
        logic [1:0]       exp_err;
        int               exp_dly;   // cycles from start to rsp_valid; -1 when no start
    } vec_t;

    vec_t vt[10];

    initial begin
        vt[0] = '{OP_ADD, 8'd15,  8'd10,  4'd3,  2, 16'h0019, ERR_OK,      3};
        vt[1] = '{OP_SUB, 8'd20,  8'd5,   4'd4,  3, 16'h000F, ERR_OK,      4};
        vt[2] = '{OP_MUL, 8'd7,   8'd3,   4'd5,  1, 16'h0015, ERR_OK,      2};
        vt[3] = '{OP_SUB, 8'd5,   8'd20,  4'd6,  2, 16'hFFF1, ERR_OK,      3};
        vt[4] = '{OP_MUL, 8'd255, 8'd255, 4'd7,  4, 16'hFE01, ERR_OK,      5};
        vt[5] = '{OP_ADD, 8'd255, 8'd255, 4'd8,  8, 16'h01FE, ERR_OK,      9};
        vt[6] = '{OP_DIV, 8'd40,  8'd5,   4'd9,  0, 16'h0000, ERR_ILLEGAL, -1};
        vt[7] = '{OP_MUL, 8'd12,  8'd12,  4'd10, 0, 16'h0000, ERR_TIMEOUT, 9};
        vt[8] = '{OP_ADD, 8'd1,   8'd2,   4'd11, 9, 16'h0000, ERR_TIMEOUT, 9};
        vt[9] = '{OP_SUB, 8'd100, 8'd1,   4'd12, 1, 16'h0063, ERR_OK,      2};

        // ---------------- reset ----------------
        rst = 1'b1; rsp_ready = 1'b0;
        drive_cmd(OP_ADD, 8'd1, 8'd1, 4'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("reset_outputs",
                {cmd_ready, alu_start, alu_opcode, alu_operand_A, alu_operand_B, rsp_valid,
                 rsp_result, rsp_opcode, rsp_tag, rsp_err, busy, fifo_count}, 64'h0);
        end
        rst = 1'b0; cmd_valid = 1'b0;
        #1;
        chk("ready_after_reset", cmd_ready, 1'b1);
        tick();

        // ---------------- table-driven single commands ----------------
        for (int v = 0; v < 10; v++) begin
            int s0;
            int cyc;
            int start_cyc;
            rsp_ready = 1'b1;
            drive_cmd(vt[v].op, vt[v].a, vt[v].b, vt[v].tag);
            if (vt[v].op != OP_DIV) lat_q.push_back(vt[v].lat);
            s0 = start_count;
            chk($sformatf("v%0d_cmd_ready", v), cmd_ready, 1'b1);
            tick();
            cmd_valid = 1'b0;
            chk($sformatf("v%0d_count_after_push", v), {busy, fifo_count}, {1'b1, 3'd1});
            cyc = 0; start_cyc = -1;
            while (!rsp_valid && cyc < 40) begin
                if (alu_start && start_cyc < 0) begin
                    start_cyc = cyc;
                    chk($sformatf("v%0d_issue", v), {alu_opcode, alu_operand_A, alu_operand_B},
                        {vt[v].op, vt[v].a, vt[v].b});
                end
                tick();
                cyc++;
            end
            chk($sformatf("v%0d_rsp_seen", v), rsp_valid, 1'b1);
            chk($sformatf("v%0d_rsp", v), {rsp_result, rsp_err, rsp_tag, rsp_opcode},
                {vt[v].exp_res, vt[v].exp_err, vt[v].tag, vt[v].op});
            if (vt[v].exp_dly < 0) begin
                chk($sformatf("v%0d_no_start", v), start_count - s0, 0);
            end else begin
                chk($sformatf("v%0d_latency", v), cyc - start_cyc, vt[v].exp_dly);
            end
            tick();
            chk($sformatf("v%0d_rsp_dropped", v), rsp_valid, 1'b0);
            repeat (3) tick();
        end

        // ---------------- burst while response stalled ----------------
        rsp_ready = 1'b0;
        drive_cmd(OP_ADD, 8'd1, 8'd1, 4'd0);
        lat_q.push_back(1);
        exp_q.push_back(predict(OP_ADD, 8'd1, 8'd1, 4'd0, 1));
        tick();
        cmd_valid = 1'b0;
        for (int c = 0; c < 20 && !rsp_valid; c++) tick();
        chk("burst_stalled_resp", rsp_valid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            logic [1:0] op;
            op = 2'(i % 3);
            drive_cmd(op, 8'(10 + i), 8'(3 + i), 4'(i + 1));
            chk($sformatf("burst_ready_%0d", i), cmd_ready, 1'b1);
            lat_q.push_back(i + 1);
            exp_q.push_back(predict(op, 8'(10 + i), 8'(3 + i), 4'(i + 1), i + 1));
            tick();
        end
        drive_cmd(OP_SUB, 8'd99, 8'd9, 4'd15);
        chk("burst_full", {cmd_ready, fifo_count}, {1'b0, 3'd4});
        tick();
        chk("burst_no_overflow", fifo_count, 3'd4);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
            check_rsp();
            tick();
        end
        chk("burst_drained", exp_q.size(), 0);
        repeat (3) tick();

        // ---------------- reset while a MUL waits ----------------
        drive_cmd(OP_MUL, 8'd9, 8'd9, 4'd13);
        lat_q.push_back(0);
        tick();
        drive_cmd(OP_ADD, 8'd2, 8'd2, 4'd14);
        lat_q.push_back(1);
        tick();
        cmd_valid = 1'b0;
        chk("rst_wait_started", alu_start, 1'b1);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("rst_wait_cleared", {busy, fifo_count, rsp_valid, cmd_ready, alu_start}, 64'h0);
        rst = 1'b0;
        lat_q.delete();
        exp_q.delete();
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 20; c++) begin
                if (rsp_valid) seen++;
                tick();
            end
            chk("rst_wait_no_resp", seen, 0);
        end

        // ---------------- randomized traffic ----------------
        begin
            int sent;
            int budget;
            int rl;
            sent = 0; budget = 0;
            while ((sent < 40 || exp_q.size() > 0) && budget < 8000) begin
                cmd_valid = 1'b0;
                if (sent < 40 && $urandom_range(0, 9) < 7) begin
                    drive_cmd(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 4'($urandom));
                end
                rsp_ready = ($urandom_range(0, 9) < 6);
                rl = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 9);
                if (cmd_valid && cmd_ready) begin
                    exp_q.push_back(predict(cmd_opcode, cmd_a, cmd_b, cmd_tag, rl));
                    if (cmd_opcode != OP_DIV) lat_q.push_back(rl);
                    sent++;
                end
                check_rsp();
                tick();
                budget++;
            end
            cmd_valid = 1'b0;
            chk("random_drained", exp_q.size(), 0);
            chk("random_sent", sent, 40);
        end
        repeat (3) tick();
        chk("final_idle", {busy, rsp_valid, fifo_count}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
